// File: rtl/mem_bus_ctrl.sv
`timescale 1ns/1ps
// mem_bus_ctrl: byte/half/word load-store controller in front of a word-wide synchronous RAM
module mem_bus_ctrl #(
  parameter int unsigned MEM_WORDS = 128,
  parameter int unsigned RAM_AW = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_signed,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [47:0]       ram_dout
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
  state_t state, nxt;
  logic l_we, l_sg, l_err, fault, accept, unused_hi;
  logic [1:0] l_size, l_off;
  logic [15:0] l_wd;
  logic [31:0] word, lane, mask, ins, merged, loaded;
  assign unused_hi = ^ram_dout[47:32];
  assign word = ram_dout[31:0];
  assign accept = state == IDLE && req;
  assign fault = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
                 addr[31:22] != '0 || 32'(addr[21:2]) >= MEM_WORDS;
  // the addressed lane lands in the low bits; half accesses are aligned so one shift serves both
  assign lane = word >> {l_off, 3'b000};
  assign loaded = l_size == 2'b00 ? {{24{l_sg & lane[7]}}, lane[7:0]} :
                  l_size == 2'b01 ? {{16{l_sg & lane[15]}}, lane[15:0]} : word;
  assign mask = (l_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {l_off, 3'b000};
  assign ins = l_size == 2'b00 ? {4{l_wd[7:0]}} : {2{l_wd}};
  assign merged = (word & ~mask) | (ins & mask);
  assign ram_we = state == WR;
  assign ack = state == DONE;
  assign err = ack & l_err;
  assign busy = state != IDLE;
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE: nxt = !req ? IDLE : fault ? DONE : (we && size == 2'b10) ? WR : RD;
      RD: nxt = CAP;
      CAP: nxt = l_we ? WR : DONE;
      WR: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdata <= '0;
      ram_addr <= '0;
      ram_din <= '0;
      l_we <= 1'b0;
      l_sg <= 1'b0;
      l_err <= 1'b0;
      l_size <= '0;
      l_off <= '0;
      l_wd <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        l_we <= we;
        l_size <= size;
        l_sg <= ld_signed;
        l_off <= addr[1:0];
        l_wd <= wdata[15:0];
        l_err <= fault;
        ram_addr <= RAM_AW'(addr[21:2]);
        if (!fault && we) ram_din <= wdata;
      end
      if (state == CAP && l_we) ram_din <= merged;
      if (state == CAP && !l_we) rdata <= loaded;
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
// tb_mem_bus_ctrl: randomized and directed checks against a byte-level memory model
module tb_mem_bus_ctrl;
  typedef struct packed {
    logic w;
    logic [1:0] sz;
    logic sg;
    logic [31:0] a;
    logic [31:0] d;
    logic chk;
    logic [31:0] x;
  } op_t;
  logic clk = 0, rst = 1, req = 0, we = 0, ld_signed = 0, init = 1;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata, ram_din;
  logic ack, err, busy, ram_we;
  logic [19:0] ram_addr;
  logic [47:0] ram_dout;
  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic [31:0] ref_rdata;
  int errors = 0, checks = 0, wr_cnt = 0, ack_cnt = 0, bad_err = 0, oob = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .ld_signed(ld_signed),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // synchronous RAM: one-cycle read latency, upper bits junk on reads and floating on writes
  always @(posedge clk) begin
    if (init) for (int i = 0; i < 128; i++) mem[i] <= 0;
    else if (ram_we) begin
      if (ram_addr < 128) mem[ram_addr[6:0]] <= ram_din;
      else oob <= oob + 1;
    end
    ram_dout <= ram_we ? 48'hzzzz_zzzz_zzzz : {16'($urandom), mem[ram_addr[6:0]]};
    if (ram_we) wr_cnt <= wr_cnt + 1;
    if (ack) ack_cnt <= ack_cnt + 1;
    if (err && !ack) bad_err <= bad_err + 1;
  end

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic e, output logic [31:0] rd,
                         output int nw);
    int w0 = wr_cnt;
    we = w; size = sz; ld_signed = sg; addr = a; wdata = d; req = 1;
    @(posedge clk); #1;
    req = 0; we = 1'($urandom); size = 2'($urandom); ld_signed = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    lat = 0; e = 1'bx; rd = 'x;
    for (int i = 1; i <= 8; i++) begin
      if (ack) begin
        lat = i; e = err; rd = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    nw = wr_cnt - w0;
  endtask

  function automatic void model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                                input logic [31:0] d, output int lat, output logic e, output logic [31:0] rd,
                                output int nw);
    int n = 1 << sz;
    int o = int'(a % 4);
    int idx = int'(a / 4);
    logic [31:0] wv;
    e = sz == 3 || a % n != 0 || a >= 4 * 128;
    rd = ref_rdata;
    nw = 0;
    lat = 1;
    if (!e) begin
      wv = ref_mem[idx];
      if (w) begin
        for (int i = 0; i < n; i++) wv[8*(o+i) +: 8] = d[8*i +: 8];
        ref_mem[idx] = wv;
        nw = 1;
        lat = n == 4 ? 2 : 4;
      end else begin
        rd = 0;
        for (int i = 0; i < n; i++) rd[8*i +: 8] = wv[8*(o+i) +: 8];
        if (sg && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
        ref_rdata = rd;
        lat = 3;
      end
    end
  endfunction

  task automatic test_reset();
    checks += 7;
    if (rdata !== 0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    if (ack !== 0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    if (err !== 0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    if (busy !== 0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (ram_we !== 0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    if (ram_addr !== 0) begin errors++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
    if (ram_din !== 0) begin errors++; $display("FAIL reset_ram_din got %h exp 0", ram_din); end
  endtask

  task automatic test_word();
    op_t ops [2];
    int ol, xl, on, xn;
    logic oe, xe;
    logic [31:0] orr, xr;
    ops[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    ops[1] = '{1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF};
    foreach (ops[k]) begin
      run_req(ops[k].w, ops[k].sz, ops[k].sg, ops[k].a, ops[k].d, ol, oe, orr, on);
      model(ops[k].w, ops[k].sz, ops[k].sg, ops[k].a, ops[k].d, xl, xe, xr, xn);
      if (ops[k].chk) xr = ops[k].x;
      checks += 4;
      if (ol !== xl) begin errors++; $display("FAIL word%0d latency got %0d exp %0d", k, ol, xl); end
      if (oe !== xe) begin errors++; $display("FAIL word%0d err got %b exp %b", k, oe, xe); end
      if (orr !== xr) begin errors++; $display("FAIL word%0d rdata got %h exp %h", k, orr, xr); end
      if (on !== xn) begin errors++; $display("FAIL word%0d writes got %0d exp %0d", k, on, xn); end
    end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_ram4 got %h exp deadbeef", mem[4]); end
  endtask

  task automatic test_subword();
    op_t ops [6];
    int ol, xl, on, xn;
    logic oe, xe;
    logic [31:0] orr, xr;
    ops[0] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA, 1'b0, 32'h0};
    ops[1] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADAAEF};
    ops[2] = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, 32'hFFFFFFAA};
    ops[3] = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 32'h000000AA};
    ops[4] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFFDEAD};
    ops[5] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0000AAEF};
    foreach (ops[k]) begin
      run_req(ops[k].w, ops[k].sz, ops[k].sg, ops[k].a, ops[k].d, ol, oe, orr, on);
      model(ops[k].w, ops[k].sz, ops[k].sg, ops[k].a, ops[k].d, xl, xe, xr, xn);
      if (ops[k].chk) xr = ops[k].x;
      checks += 4;
      if (ol !== xl) begin errors++; $display("FAIL sub%0d latency got %0d exp %0d", k, ol, xl); end
      if (oe !== xe) begin errors++; $display("FAIL sub%0d err got %b exp %b", k, oe, xe); end
      if (orr !== xr) begin errors++; $display("FAIL sub%0d rdata got %h exp %h", k, orr, xr); end
      if (on !== xn) begin errors++; $display("FAIL sub%0d writes got %0d exp %0d", k, on, xn); end
    end
  endtask

  task automatic test_faults();
    op_t ops [5];
    int ol, on;
    logic oe;
    logic [31:0] orr, keep;
    ops[0] = '{1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0};
    ops[1] = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h11111111, 1'b0, 32'h0};
    ops[2] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
    ops[3] = '{1'b0, 2'd2, 1'b0, 32'h00400000, 32'h0, 1'b0, 32'h0};
    ops[4] = '{1'b1, 2'd1, 1'b0, 32'h15, 32'h2222, 1'b0, 32'h0};
    keep = ref_rdata;
    foreach (ops[k]) begin
      run_req(ops[k].w, ops[k].sz, ops[k].sg, ops[k].a, ops[k].d, ol, oe, orr, on);
      checks += 4;
      if (ol !== 1) begin errors++; $display("FAIL fault%0d latency got %0d exp 1", k, ol); end
      if (oe !== 1) begin errors++; $display("FAIL fault%0d err got %b exp 1", k, oe); end
      if (orr !== keep) begin errors++; $display("FAIL fault%0d rdata got %h exp %h", k, orr, keep); end
      if (on !== 0) begin errors++; $display("FAIL fault%0d writes got %0d exp 0", k, on); end
    end
  endtask

  task automatic test_back_to_back();
    int ol, xl, on, xn;
    logic oe, xe, w, sg;
    logic [1:0] sz;
    logic [31:0] orr, xr, a, d;
    for (int k = 0; k < 80; k++) begin
      w = 1'($urandom);
      sg = 1'($urandom);
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 9) == 0 ? $urandom : ($urandom_range(0, 3) == 0 ? $urandom_range(0, 600) : $urandom_range(0, 47));
      d = $urandom;
      run_req(w, sz, sg, a, d, ol, oe, orr, on);
      model(w, sz, sg, a, d, xl, xe, xr, xn);
      checks += 4;
      if (ol !== xl) begin errors++; $display("FAIL rnd%0d latency got %0d exp %0d", k, ol, xl); end
      if (oe !== xe) begin errors++; $display("FAIL rnd%0d err got %b exp %b", k, oe, xe); end
      if (orr !== xr) begin errors++; $display("FAIL rnd%0d rdata got %h exp %h", k, orr, xr); end
      if (on !== xn) begin errors++; $display("FAIL rnd%0d writes got %0d exp %0d", k, on, xn); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w4 = ref_mem[4], w8 = ref_mem[8];
    int a0 = ack_cnt, w0 = wr_cnt;
    we = 1; size = 0; ld_signed = 0; addr = 32'h10; wdata = 32'h55; req = 1;
    @(posedge clk); #1;
    we = 1; size = 2; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 0;
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL mid_busy_cap got %b exp 1", busy); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    ref_rdata = 0;
    checks += 3;
    if (busy !== 0) begin errors++; $display("FAIL mid_busy_after got %b exp 0", busy); end
    if (ram_we !== 0) begin errors++; $display("FAIL mid_ram_we got %b exp 0", ram_we); end
    if (rdata !== 0) begin errors++; $display("FAIL mid_rdata got %h exp 0", rdata); end
    repeat (6) @(posedge clk);
    #1;
    checks += 4;
    if (ack_cnt !== a0) begin errors++; $display("FAIL mid_acks got %0d exp %0d", ack_cnt, a0); end
    if (wr_cnt !== w0) begin errors++; $display("FAIL mid_writes got %0d exp %0d", wr_cnt, w0); end
    if (mem[4] !== w4) begin errors++; $display("FAIL mid_word4 got %h exp %h", mem[4], w4); end
    if (mem[8] !== w8) begin errors++; $display("FAIL mid_word8 got %h exp %h", mem[8], w8); end
  endtask

  task automatic test_final();
    checks += 2;
    if (bad_err !== 0) begin errors++; $display("FAIL err_without_ack got %0d exp 0", bad_err); end
    if (oob !== 0) begin errors++; $display("FAIL oob_writes got %0d exp 0", oob); end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL ram%0d got %h exp %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 0;
    ref_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    init = 0;
    rst = 0;
    @(posedge clk); #1;
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    test_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
